// File: rtl/reg_shift_driver_pkg.sv
// reg_shift_pkg: shared states, direction codes and gap counter width for reg_shift_driver
package reg_shift_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, WAIT, DONE} state_t;
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT = 1'b1;
  localparam int GAP_W = 4;
endpackage

// File: rtl/reg_shift_driver_if.sv
// reg_shift_driver_if: word handshake from the command source into reg_shift_driver
interface reg_shift_driver_if #(parameter int WIDTH = 4);
  logic in_valid;
  logic in_ready;
  logic in_dir;
  logic abort;
  logic [WIDTH-1:0] in_data;
  modport master(output in_valid, in_data, in_dir, abort, input in_ready);
  modport slave(input in_valid, in_data, in_dir, abort, output in_ready);
endinterface

// File: rtl/reg_shift_driver_shift_gap_timer.sv
// shift_gap_timer: loads GAP-1 on entry to WAIT and flags expiry on the last idle cycle
module shift_gap_timer import reg_shift_pkg::*; #(parameter int GAP = 1) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expired
);
  logic [GAP_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= GAP_W'(GAP - 1);
    else if (cnt != '0) cnt <= cnt - GAP_W'(1);
  assign expired = cnt == '0;
endmodule

// File: rtl/reg_shift_driver.sv
// reg_shift_driver: serialises a handshaked word onto sr/ir or sl/il shift strobes
// REG_SHIFT_DRIVER_CLEAR_EN adds a one-cycle cl strobe before the first shift
module reg_shift_driver import reg_shift_pkg::*; #(
  parameter int WIDTH = 4,
  parameter int GAP = 0
) (
  input  logic clk,
  input  logic rst_n,
  reg_shift_driver_if.slave bus,
  output logic cl,
  output logic sr,
  output logic ir,
  output logic sl,
  output logic il,
  output logic busy,
  output logic done
);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef REG_SHIFT_DRIVER_CLEAR_EN
  localparam state_t FIRST = CLEAR;
`else
  localparam state_t FIRST = SHIFT;
`endif
  state_t state, nstate;
  logic [WIDTH-1:0] shreg, src;
  logic [CW-1:0] cnt;
  logic dir_q, sdir, hs, launch, expired;
  assign hs = bus.in_valid && state == IDLE;
  assign bus.in_ready = state == IDLE;
  assign busy = state != IDLE;
  // the first strobe launches straight from the handshake, before the word is latched
  assign src = state == IDLE ? bus.in_data : shreg;
  assign sdir = state == IDLE ? bus.in_dir : dir_q;
  assign launch = nstate == SHIFT;
  generate
    if (GAP > 0) begin : g_gap
      shift_gap_timer #(.GAP(GAP)) u_timer (
        .clk(clk),
        .rst_n(rst_n),
        .load(state == SHIFT && nstate == WAIT),
        .expired(expired)
      );
    end else begin : g_nogap
      assign expired = 1'b1;
    end
  endgenerate
  always_comb begin
    nstate = state;
    case (state)
      IDLE:  nstate = hs ? FIRST : IDLE;
      CLEAR: nstate = bus.abort ? IDLE : SHIFT;
      SHIFT: nstate = bus.abort ? IDLE : cnt == CW'(WIDTH) ? DONE : GAP > 0 ? WAIT : SHIFT;
      WAIT:  nstate = bus.abort ? IDLE : expired ? SHIFT : WAIT;
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      cnt <= '0;
      dir_q <= DIR_RIGHT;
      sr <= 1'b0;
      ir <= 1'b0;
      sl <= 1'b0;
      il <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nstate;
      done <= nstate == DONE;
      sr <= launch && sdir == DIR_RIGHT;
      ir <= launch && sdir == DIR_RIGHT && src[0];
      sl <= launch && sdir == DIR_LEFT;
      il <= launch && sdir == DIR_LEFT && src[WIDTH-1];
      if (hs) dir_q <= bus.in_dir;
      shreg <= launch ? (sdir == DIR_RIGHT ? src >> 1 : src << 1) : hs ? bus.in_data : shreg;
      cnt <= launch ? (state == IDLE ? CW'(1) : cnt + CW'(1)) : hs ? '0 : cnt;
    end
`ifdef REG_SHIFT_DRIVER_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cl <= 1'b0;
    else cl <= nstate == CLEAR;
`else
  assign cl = 1'b0;
`endif
endmodule

// File: tb/tb_reg_shift_driver.sv
// tb_reg_shift_driver: directed checks of reg_shift_driver against a target register model
module tb_reg_shift_driver;
`ifdef REG_SHIFT_DRIVER_CLEAR_EN
  localparam int O = 1;
`else
  localparam int O = 0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int failures = 0;
  logic cl0, sr0, ir0, sl0, il0, busy0, done0;
  logic cl2, sr2, ir2, sl2, il2, busy2, done2;
  logic [3:0] m0, m2, pv0;
  logic pre0 = 1'b0;
  logic [7:0] obs0, obs2;
  reg_shift_driver_if #(.WIDTH(4)) b0();
  reg_shift_driver_if #(.WIDTH(4)) b2();
  reg_shift_driver #(.WIDTH(4), .GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0), .cl(cl0), .sr(sr0), .ir(ir0),
    .sl(sl0), .il(il0), .busy(busy0), .done(done0)
  );
  reg_shift_driver #(.WIDTH(4), .GAP(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2), .cl(cl2), .sr(sr2), .ir(ir2),
    .sl(sl2), .il(il2), .busy(busy2), .done(done2)
  );
  assign obs0 = {cl0, sr0, ir0, sl0, il0, done0, busy0, b0.in_ready};
  assign obs2 = {cl2, sr2, ir2, sl2, il2, done2, busy2, b2.in_ready};
  always #5 clk = ~clk;
  // target register: sr shifts ir in at the MSB, sl shifts il in at the LSB
  always @(posedge clk) begin
    m0 <= pre0 ? pv0 : cl0 ? 4'b0 : sr0 ? {ir0, m0[3:1]} : sl0 ? {m0[2:0], il0} : m0;
    m2 <= cl2 ? 4'b0 : sr2 ? {ir2, m2[3:1]} : sl2 ? {m2[2:0], il2} : m2;
  end

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs0 !== 8'b0000_0001) begin failures++; $display("FAIL reset0 got=%b exp=00000001", obs0); end
    checks++;
    if (obs2 !== 8'b0000_0001) begin failures++; $display("FAIL reset2 got=%b exp=00000001", obs2); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs0 !== 8'b0000_0001) begin failures++; $display("FAIL post_reset_idle got=%b exp=00000001", obs0); end
  endtask

  task automatic test_shift(input string name, input logic [3:0] d, input logic dir);
    logic [7:0] want;
    logic s, bt;
    for (int i = 0; i < 50 && b0.in_ready !== 1'b1; i++) @(negedge clk);
    checks++;
    if (b0.in_ready !== 1'b1) begin failures++; $display("FAIL %s ready got=%b exp=1", name, b0.in_ready); end
    b0.in_valid = 1'b1;
    b0.in_data = d;
    b0.in_dir = dir;
    @(negedge clk);
    b0.in_valid = 1'b0;
    b0.in_data = ~d;
    b0.in_dir = ~dir;
    for (int k = 0; k <= O + 5; k++) begin
      s = k >= O && k < O + 4;
      bt = s ? (dir ? d[3 - (k - O)] : d[k - O]) : 1'b0;
      want = k == O + 5 ? 8'b0000_0001 :
             {O == 1 && k == 0, s && !dir, bt && !dir, s && dir, bt && dir, k == O + 4, 1'b1, 1'b0};
      checks++;
      if (obs0 !== want) begin failures++; $display("FAIL %s cycle%0d got=%b exp=%b", name, k, obs0, want); end
      @(negedge clk);
    end
    checks++;
    if (m0 !== d) begin failures++; $display("FAIL %s model got=%b exp=%b", name, m0, d); end
  endtask

  task automatic test_gap();
    logic [7:0] want;
    logic s, bt;
    logic [3:0] d = 4'b0110;
    b2.in_valid = 1'b1;
    b2.in_data = d;
    b2.in_dir = 1'b0;
    @(negedge clk);
    b2.in_data = 4'b1001;
    for (int k = 0; k <= O + 12; k++) begin
      s = k >= O && (k - O) % 3 == 0 && k - O <= 9;
      bt = s ? d[(k - O) / 3] : 1'b0;
      want = k >= O + 11 ? 8'b0000_0001 : {O == 1 && k == 0, s, bt, 2'b00, k == O + 10, 1'b1, 1'b0};
      checks++;
      if (obs2 !== want) begin failures++; $display("FAIL gap cycle%0d got=%b exp=%b", k, obs2, want); end
      if (k == O + 10) b2.in_valid = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (m2 !== d) begin failures++; $display("FAIL gap model got=%b exp=%b", m2, d); end
  endtask

  task automatic test_abort();
    logic [7:0] want;
    logic s;
    logic [3:0] d = 4'b1100;
    b0.in_valid = 1'b1;
    b0.in_data = d;
    b0.in_dir = 1'b1;
    @(negedge clk);
    b0.in_valid = 1'b0;
    for (int k = 0; k <= O + 1; k++) begin
      s = k >= O;
      want = {O == 1 && k == 0, 2'b00, s, s && d[3 - (k - O)], 1'b0, 1'b1, 1'b0};
      checks++;
      if (obs0 !== want) begin failures++; $display("FAIL abort cycle%0d got=%b exp=%b", k, obs0, want); end
      if (k == O + 1) b0.abort = 1'b1;
      @(negedge clk);
    end
    b0.abort = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (obs0 !== 8'b0000_0001) begin failures++; $display("FAIL abort_idle cycle%0d got=%b exp=00000001", k, obs0); end
      @(negedge clk);
    end
    checks++;
    if (m0[1:0] !== 2'b11) begin failures++; $display("FAIL abort_partial got=%b exp=11", m0[1:0]); end
    test_shift("after_abort", 4'b0011, 1'b0);
  endtask

  task automatic test_async_reset();
    b0.in_valid = 1'b1;
    b0.in_data = 4'b1011;
    b0.in_dir = 1'b0;
    @(negedge clk);
    b0.in_valid = 1'b0;
    for (int k = 0; k < O + 2; k++) @(negedge clk);
    checks++;
    if (sr0 !== 1'b1) begin failures++; $display("FAIL third_strobe got=%b exp=1", sr0); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs0 !== 8'b0000_0001) begin failures++; $display("FAIL async_reset got=%b exp=00000001", obs0); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs0 !== 8'b0000_0001) begin failures++; $display("FAIL release got=%b exp=00000001", obs0); end
    test_shift("post_reset", 4'b1011, 1'b0);
  endtask

  task automatic test_clear();
    pv0 = 4'b1010;
    pre0 = 1'b1;
    @(negedge clk);
    pre0 = 1'b0;
    test_shift("clear", 4'b1111, 1'b0);
  endtask

  initial begin
    b0.in_valid = 1'b0;
    b0.abort = 1'b0;
    b0.in_data = 4'b0;
    b0.in_dir = 1'b0;
    b2.in_valid = 1'b0;
    b2.abort = 1'b0;
    b2.in_data = 4'b0;
    b2.in_dir = 1'b0;
    test_reset();
    test_shift("right", 4'b1011, 1'b0);
    test_shift("left", 4'b1011, 1'b1);
    test_gap();
    test_abort();
    test_async_reset();
    test_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
